// File: rtl/ccd_line_capture.sv
// Receive side of the TCD1500C timing generator: skips dummy pixels, samples the ADC
// a fixed delay after each sp edge and streams framed pixels through a small FIFO.
module ccd_line_capture #(
  parameter int DATA_W     = 12,
  parameter int LEAD_SKIP  = 64,
  parameter int NUM_PIX    = 5340,
  parameter int SAMPLE_DLY = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sh,
  input  logic              sp,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              enable,
  input  logic              clr_err,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              overflow,
  output logic              sync_err,
  output logic [15:0]       line_cnt
);

  localparam int MAXC  = (LEAD_SKIP > NUM_PIX) ? LEAD_SKIP : NUM_PIX;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam int DLY_W = 5;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int WW    = DATA_W + 2;

  localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'((LEAD_SKIP == 0) ? 0 : LEAD_SKIP - 1);
  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(NUM_PIX - 1);
  localparam logic [DLY_W-1:0] DLY_INIT  = DLY_W'(SAMPLE_DLY - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SH, SKIP, CAPTURE} state_t;

  state_t             state;
  logic               sh_q, sp_q;
  logic [CNT_W-1:0]   cnt;
  logic               pend;
  logic [DLY_W-1:0]   dly;
  logic               cap_vld, cap_sof, cap_eol;
  logic [DATA_W-1:0]  cap_data;

  logic sh_rise, sh_fall, sp_rise;
  logic expire, collide, in_cap, adv, last_pix;

  assign sh_rise  = sh & ~sh_q;
  assign sh_fall  = ~sh & sh_q;
  assign sp_rise  = sp & ~sp_q;
  assign in_cap   = (state == CAPTURE) && !sh_rise;
  assign expire   = pend && (dly == '0);
  assign collide  = pend && (dly != '0) && sp_rise;
  // A dropped (collided) sample still consumes a pixel slot so framing survives.
  assign adv      = in_cap && (expire || collide);
  assign last_pix = (cnt == PIX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= 1'b0;
      sp_q <= 1'b0;
    end else begin
      sh_q <= sh;
      sp_q <= sp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pend     <= 1'b0;
      dly      <= '0;
      cap_vld  <= 1'b0;
      cap_sof  <= 1'b0;
      cap_eol  <= 1'b0;
      cap_data <= '0;
      busy     <= 1'b0;
      sync_err <= 1'b0;
      line_cnt <= '0;
    end else begin
      cap_vld <= 1'b0;
      if (clr_err) sync_err <= 1'b0;
      if (pend) begin
        if (dly == '0) pend <= 1'b0;
        else           dly  <= dly - DLY_W'(1);
      end
      case (state)
        IDLE: begin
          if (enable && sh_rise) begin
            state <= WAIT_SH;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        WAIT_SH: begin
          cnt <= '0;
          if (sh_fall) state <= (LEAD_SKIP == 0) ? CAPTURE : SKIP;
        end
        SKIP, CAPTURE: begin
          if (sh_rise) begin
            // short line: abandon it, keep what already reached the FIFO
            sync_err <= 1'b1;
            pend     <= 1'b0;
            cnt      <= '0;
            state    <= enable ? WAIT_SH : IDLE;
            busy     <= enable;
          end else if (state == SKIP) begin
            if (sp_rise) begin
              if (cnt == SKIP_LAST) begin
                cnt   <= '0;
                state <= CAPTURE;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end else begin
            if (expire) begin
              cap_vld  <= 1'b1;
              cap_data <= adc_data;
              cap_sof  <= (cnt == '0);
              cap_eol  <= last_pix;
            end
            if (collide) sync_err <= 1'b1;
            if (sp_rise && !(adv && last_pix)) begin
              pend <= 1'b1;
              dly  <= DLY_INIT;
            end
            if (adv) begin
              if (last_pix) begin
                state    <= IDLE;
                busy     <= 1'b0;
                pend     <= 1'b0;
                cnt      <= '0;
                line_cnt <= line_cnt + 16'd1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Show-ahead FIFO; extra pointer bit separates full from empty.
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wp, rp;
  logic          full, rd, wr;

  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign m_valid = (wp != rp);
  assign rd      = m_valid && m_ready;
  assign wr      = cap_vld && (!full || rd);
  assign {m_sof, m_eol, m_data} = m_valid ? mem[rp[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (wr) mem[wp[AW-1:0]] <= {cap_sof, cap_eol, cap_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wp <= wp + (AW+1)'(1);
      if (rd) rp <= rp + (AW+1)'(1);
      if (clr_err) overflow <= 1'b0;
      if (cap_vld && !wr) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ccd_line_capture.sv
// Directed + randomized bench for ccd_line_capture against a pixel-list reference model.
module tb_ccd_line_capture;
  localparam int DW = 12, LS = 2, NP = 6, SD = 3, FD = 4;

  logic clk = 1'b0, rst_n = 1'b0, sh = 1'b0, sp = 1'b0;
  logic enable = 1'b0, clr_err = 1'b0, m_ready = 1'b0;
  logic [DW-1:0] adc_data = '0, m_data;
  logic m_sof, m_eol, m_valid, busy, overflow, sync_err;
  logic [15:0] line_cnt;

  int checks = 0, errors = 0, cyc = 0, rdy_mode = 1;
  logic [DW-1:0] adc_hist [0:39999];
  int sp_edges[$];
  logic [DW+1:0] exp_q[$], got_q[$];
  int got_cyc[$];
  logic hold_q = 1'b0;
  logic [DW+1:0] hold_w;

  always #5 clk = ~clk;

  ccd_line_capture #(.DATA_W(DW), .LEAD_SKIP(LS), .NUM_PIX(NP), .SAMPLE_DLY(SD),
                     .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .sh(sh), .sp(sp), .adc_data(adc_data), .enable(enable),
    .clr_err(clr_err), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .overflow(overflow), .sync_err(sync_err),
    .line_cnt(line_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    adc_data = DW'($urandom);
    adc_hist[cyc+1] = adc_data;
    case (rdy_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = ($urandom_range(0, 7) != 0);
    endcase
    clr_err = 1'b0;
  endtask

  task automatic sh_pulse();
    sp_edges.delete();
    sh = 1'b1; repeat (3) tick();
    sh = 1'b0; repeat (3) tick();
  endtask

  task automatic sp_pulse(input int per);
    sp = 1'b1;
    sp_edges.push_back(cyc + 1);
    tick();
    sp = 1'b0;
    repeat (per - 1) tick();
  endtask

  // Reference: after LS dummies, pixel p sits on edge t and is sampled from the ADC at
  // t+SD unless the next sp edge arrives strictly earlier; limit caps stored words.
  task automatic predict(input int limit);
    int p, n, t;
    bit drop;
    p = 0; n = 0;
    for (int i = LS; i < sp_edges.size() && p < NP; i++) begin
      t = sp_edges[i];
      drop = (i + 1 < sp_edges.size()) && (sp_edges[i+1] - t < SD);
      if (!drop) begin
        if (n < limit) exp_q.push_back({p == 0, p == NP - 1, adc_hist[t+SD]});
        n++;
      end
      p++;
    end
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 400;
    while (got_q.size() < exp_q.size() && budget > 0) begin tick(); budget--; end
    repeat (SD + 8) tick();
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"}, 32'(m_data), 0);
    chk({tag, "_sof"}, 32'(m_sof), 0);
    chk({tag, "_eol"}, 32'(m_eol), 0);
    chk({tag, "_valid"}, 32'(m_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_serr"}, 32'(sync_err), 0);
    chk({tag, "_lcnt"}, 32'(line_cnt), 0);
  endtask

  // Output monitor: collects transfers and checks words hold while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) chk("hold", {17'd0, m_valid, m_sof, m_eol, m_data}, {17'd0, 1'b1, hold_w});
      if (m_valid && m_ready) begin
        got_q.push_back({m_sof, m_eol, m_data});
        got_cyc.push_back(cyc);
      end
      hold_q = m_valid && !m_ready;
      hold_w = {m_sof, m_eol, m_data};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    enable = 1'b1;
    repeat (3) tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // basic line with latency check
    sh_pulse();
    chk("basic_busy", 32'(busy), 1);
    repeat (LS + NP) sp_pulse(50);
    predict(99);
    chk("basic_ncyc", got_cyc.size(), NP);
    for (int i = 0; i < got_cyc.size() && i < NP; i++)
      chk("basic_lat", got_cyc[i], sp_edges[LS+i] + SD + 1);
    chk("basic_lcnt", 32'(line_cnt), 1);
    chk("basic_idle", 32'(busy), 0);
    drain("basic");

    // random sp spacing and random backpressure
    for (int l = 0; l < 3; l++) begin
      rdy_mode = 2;
      sh_pulse();
      repeat (LS + NP + 1) sp_pulse($urandom_range(SD, 60));
      repeat (5) tick();
      predict(99);
      drain("rand");
    end
    rdy_mode = 1;
    chk("rand_lcnt", 32'(line_cnt), 4);
    chk("rand_serr", 32'(sync_err), 0);
    chk("rand_ovf", 32'(overflow), 0);

    // full backpressure: FIFO fills, tail of the line is dropped
    rdy_mode = 0;
    tick();
    sh_pulse();
    repeat (LS + NP) sp_pulse(50);
    predict(FD);
    chk("bp_valid", 32'(m_valid), 1);
    chk("bp_head", 32'({m_sof, m_eol, m_data}), 32'(exp_q[0]));
    chk("bp_ovf", 32'(overflow), 1);
    chk("bp_lcnt", 32'(line_cnt), 5);
    rdy_mode = 1;
    drain("bp");
    clr_err = 1'b1; tick();
    chk("bp_clr", 32'(overflow), 0);

    // short line aborted by sh, followed by a full line
    sh_pulse();
    repeat (LS + 3) sp_pulse(50);
    predict(99);
    sh_pulse();
    chk("short_serr", 32'(sync_err), 1);
    chk("short_busy", 32'(busy), 1);
    repeat (LS + NP) sp_pulse(50);
    predict(99);
    chk("short_lcnt", 32'(line_cnt), 6);
    drain("short");
    clr_err = 1'b1; tick();
    chk("short_clr", 32'(sync_err), 0);

    // enable gating
    enable = 1'b0;
    sh_pulse();
    repeat (LS + NP) sp_pulse(50);
    chk("en0_busy", 32'(busy), 0);
    chk("en0_lcnt", 32'(line_cnt), 6);
    drain("en0");
    enable = 1'b1;
    sh_pulse();
    sp_pulse(50);
    enable = 1'b0;
    repeat (LS + NP - 1) sp_pulse(50);
    predict(99);
    chk("en_drop_busy", 32'(busy), 0);
    chk("en_drop_lcnt", 32'(line_cnt), 7);
    drain("en_drop");
    enable = 1'b1;

    // sp edges closer than the sample delay
    sh_pulse();
    repeat (LS) sp_pulse(50);
    repeat (4) sp_pulse(2);
    repeat (4) sp_pulse(50);
    predict(99);
    chk("col_serr", 32'(sync_err), 1);
    chk("col_lcnt", 32'(line_cnt), 8);
    drain("col");
    clr_err = 1'b1; tick();
    chk("col_clr", 32'(sync_err), 0);

    // reset in the middle of a line with words queued
    rdy_mode = 0;
    tick();
    sh_pulse();
    repeat (LS + 2) sp_pulse(50);
    chk("rst_pre_valid", 32'(m_valid), 1);
    chk("rst_pre_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    rdy_mode = 1;
    repeat (2) tick();
    sh_pulse();
    repeat (LS + NP) sp_pulse(50);
    predict(99);
    chk("post_rst_lcnt", 32'(line_cnt), 1);
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
